// File: rtl/halfband_filter_interp_pkg.sv
// rtl/halfband_filter_interp_pkg.sv - shared widths, coefficients, limits and FSM encoding for the halfband interpolator
package halfband_filter_interp_pkg;

  localparam int W     = 18;
  localparam int ACC_W = 37;

  localparam logic signed [W-1:0] H1 = -18'sd9220;
  localparam logic signed [W-1:0] H3 = 18'sd74920;

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC_A = 2'd1,
    MAC_B = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Clip a 2s17 value to 1s17: overflow exactly when the two top bits differ.
  function automatic logic signed [W-1:0] sat_2s17(input logic signed [W:0] v);
    if (v[W] != v[W-1]) begin
      return v[W] ? SAT_MIN : SAT_MAX;
    end
    return v[W-1:0];
  endfunction

endpackage

// File: rtl/halfband_interp_mac.sv
// rtl/halfband_interp_mac.sv - odd-phase pre-add, shared multiply, accumulate and saturate
module halfband_interp_mac
  import halfband_filter_interp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  state_e              state_i,
  input  logic signed [W-1:0] x0_i,
  input  logic signed [W-1:0] x1_i,
  input  logic signed [W-1:0] x2_i,
  input  logic signed [W-1:0] x3_i,
  output logic signed [W-1:0] odd_o
);

  logic signed [W:0]       pre;
  logic signed [W-1:0]     coef;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic signed [W-1:0]     odd_d, odd_q;

  // Symmetric taps share one coefficient, so the pair is summed before the multiply.
  always_comb begin
    if (state_i == MAC_B) begin
      pre  = {x1_i[W-1], x1_i} + {x2_i[W-1], x2_i};
      coef = H3;
    end else begin
      pre  = {x0_i[W-1], x0_i} + {x3_i[W-1], x3_i};
      coef = H1;
    end
    prod = ACC_W'(coef) * ACC_W'(pre);
  end

  always_comb begin
    acc_d = acc_q;
    odd_d = odd_q;
    case (state_i)
      MAC_A:   acc_d = prod;
      MAC_B:   acc_d = acc_q + prod;
      DONE:    odd_d = sat_2s17(acc_q[2*W-1:W-1]);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      odd_q <= '0;
    end else begin
      acc_q <= acc_d;
      odd_q <= odd_d;
    end
  end

  assign odd_o = odd_q;

endmodule

// File: rtl/halfband_filter_interp.sv
// rtl/halfband_filter_interp.sv - 7-tap halfband interpolate-by-2: delay line, MAC sequencer, phase and output mux
module halfband_filter_interp
  import halfband_filter_interp_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_clk_en,
  input  logic                out_clk_en,
  input  logic signed [W-1:0] x_in,
  output logic signed [W-1:0] y,
  output logic                y_valid,
  output logic                err
);

  logic signed [W-1:0] x0_d, x0_q, x1_d, x1_q, x2_d, x2_q, x3_d, x3_q;
  logic signed [W-1:0] y_d, y_q;
  logic signed [W-1:0] odd;
  logic                y_valid_d, y_valid_q;
  logic                err_d, err_q;
  logic                phase_d, phase_q;
  state_e              state_d, state_q;

  halfband_interp_mac u_mac (
    .clk     (clk),
    .rst_n   (reset),
    .state_i (state_q),
    .x0_i    (x0_q),
    .x1_i    (x1_q),
    .x2_i    (x2_q),
    .x3_i    (x3_q),
    .odd_o   (odd)
  );

  always_comb begin
    x0_d      = x0_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    x3_d      = x3_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    err_d     = err_q;
    phase_d   = phase_q;
    state_d   = state_q;
    if (in_clk_en) begin
      x0_d      = x_in;
      x1_d      = x0_q;
      x2_d      = x1_q;
      x3_d      = x2_q;
      y_d       = x1_q;
      y_valid_d = 1'b1;
      phase_d   = 1'b1;
      state_d   = MAC_A;
      if (state_q != IDLE || !out_clk_en) err_d = 1'b1;
    end else begin
      case (state_q)
        MAC_A:   state_d = MAC_B;
        MAC_B:   state_d = DONE;
        default: state_d = IDLE;
      endcase
      // An early or repeated odd strobe still emits whatever odd value is held.
      if (out_clk_en) begin
        y_d       = odd;
        y_valid_d = 1'b1;
        phase_d   = 1'b0;
        if (state_q != IDLE || !phase_q) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0_q      <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      x3_q      <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
      phase_q   <= 1'b0;
      state_q   <= IDLE;
    end else begin
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      x3_q      <= x3_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      err_q     <= err_d;
      phase_q   <= phase_d;
      state_q   <= state_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign err     = err_q;

endmodule

// File: doc/halfband_filter_interp.md
Name: halfband_filter_interp

Overview:
- 7-tap halfband interpolate-by-2 filter, polyphase form: the upsampling counterpart of the team's halfband decimator.
- Takes 1s17 samples at the input rate (in_clk_en) and produces 1s17 samples at twice that rate (out_clk_en), with passband gain 1.
- Even phase is a pure delay. Odd phase uses one time-shared multiplier with symmetric pre-add.
- Sits between the symbol-rate pulse-shaping stage and the upsampled DAC path.

Parameters:
- W, 18, sample width (1s17 in and out)
- H1, -18'sd9220, outer odd-phase coefficient (0s18)
- H3, 18'sd74920, inner odd-phase coefficient (0s18)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- in_clk_en  input  1  input-rate strobe; always coincident with an out_clk_en pulse
- out_clk_en  input  1  output-rate strobe (2x in_clk_en)
- x_in  input  W  input sample, 1s17
- y  output  W  output sample, 1s17
- y_valid  output  1  one-clk pulse when y updates
- err  output  1  sticky protocol-error flag

Behaviour:
- Reset: x0..x3, acc, odd_reg, y all 0; y_valid=0; err=0; FSM=IDLE; phase=0.
- Delay line: on in_clk_en, x0<=x_in, x1<=x0, x2<=x1, x3<=x2. Otherwise hold.
- Phase bit:
  - in_clk_en (with out_clk_en): phase<=1.
  - out_clk_en alone: phase<=0.
- Even output: on the in_clk_en edge, y<=x1 (pre-shift value, i.e. x[n-2] when x_in=x[n]); y_valid=1 next cycle.
- Odd output: on an out_clk_en without in_clk_en, y<=odd_reg; y_valid=1.
- Odd-phase arithmetic, all signed, post-shift delay line:
  - a1 = x0+x3 and a3 = x1+x2, each 19-bit 2s17.
  - Each product h*a is 37-bit 2s35.
  - acc (37-bit) = H1*a1 + H3*a3.
  - odd_reg = sat(acc[35:17]) to [-131072, 131071]. This applies gain x2 with truncation (floor).
- FSM, one multiplier whose operands are muxed by state:
  - IDLE: in_clk_en -> MAC_A.
  - MAC_A: acc<=H1*a1 -> MAC_B.
  - MAC_B: acc<=acc+H3*a3 -> DONE.
  - DONE: odd_reg<=sat(acc) -> IDLE.
- odd_reg is valid 3 clk after in_clk_en. The odd out_clk_en must arrive at least 4 clk after in_clk_en.
- Boundary conditions:
  - Odd out_clk_en arrives while FSM != IDLE: y<=stale odd_reg, err<=1.
  - in_clk_en while FSM != IDLE: shift anyway, restart at MAC_A, err<=1.
  - in_clk_en without out_clk_en: process normally, err<=1.
  - Two consecutive out_clk_en with no in_clk_en between (phase=0): output odd_reg again, err<=1.
  - Reset deasserted mid-MAC: all state cleared asynchronously; first output after release is even phase.
- err clears only on reset.

Decomposition:
- Shared package holds: W, ACC_W=37, H1, H3, the 1s17 saturation limits, and the FSM state encoding (IDLE, MAC_A, MAC_B, DONE).
- One sub-module, halfband_interp_mac: pre-adder select, 18x19 multiply, accumulate, and saturate. It is driven by state from the parent.
- The parent owns the delay line, FSM, phase logic and output mux.

Test Plan:
- Impulse:
  - Stimulus: x_in=131071 for one input period, then 0; strobes 8 clk apart.
  - Odd outputs over periods n0..n0+3: -9220, 74919, 74919, -9220.
  - Even output at n0+2: 131071; all other even outputs 0.
- DC:
  - Stimulus: x_in=65536 held.
  - After 4 inputs: even y=65536, odd y=65700; err=0.
- Saturation:
  - Stimulus: x sequence -131072, 131071, 131071, -131072.
  - Odd y=131071 (clipped). Mirrored sign pattern gives -131072.
- Timing violation:
  - Stimulus: odd out_clk_en 2 clk after in_clk_en.
  - y = previous odd_reg; err=1 and stays 1.
- Restart:
  - Stimulus: in_clk_en during MAC_B.
  - Delay line shifts; FSM returns to MAC_A; err=1; the next odd value is correct for the new line.
- Reset mid-operation:
  - Stimulus: reset=0 during MAC_A.
  - y=0, y_valid=0, err=0, FSM=IDLE immediately, with no clk edge required.
